// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        IMEM_WAIT  = 2'd2,
        FLUSH      = 2'd3
    } hazard_state_e;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 32;

    // A load in ID/EX whose destination feeds the instruction in IF/ID ($zero never hazards).
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating up-counter with enable and synchronous active-high reset.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         en_in,
    output logic [W-1:0] count_out
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_in && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: load-use stall, branch/jump flush sequencing, imem wait hold.
// Define HAZ_PERF_CNT_EN to build the stall/flush cycle counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int CNT_W               = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [4:0]       IF_ID_Rs_in,
    input  logic [4:0]       IF_ID_Rt_in,
    input  logic [4:0]       ID_EX_Rt_in,
    input  logic             ID_EX_MemRead_in,
    input  logic             branch_taken_in,
    input  logic             jump_in,
    input  logic             imem_ready_in,
    output logic             PC_write_out,
    output logic             IF_ID_enable_out,
    output logic             flush_jump_out,
    output logic             flush_branch_out,
    output logic             ID_EX_bubble_out,
    output logic [CNT_W-1:0] stall_cycles_out,
    output logic [CNT_W-1:0] flush_cycles_out
);

    localparam bit         MULTI_FLUSH  = (BRANCH_FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 2);

    hazard_state_e state_q, state_d;
    logic [2:0]    flush_cnt_q, flush_cnt_d;
    logic          load_use;

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        PC_write_out     = 1'b1;
        IF_ID_enable_out = 1'b1;
        flush_jump_out   = 1'b0;
        flush_branch_out = 1'b0;
        ID_EX_bubble_out = 1'b0;
        load_use = is_load_use(ID_EX_MemRead_in, ID_EX_Rt_in, IF_ID_Rs_in, IF_ID_Rt_in);

        if (reset_in) begin
            PC_write_out     = 1'b0;
            IF_ID_enable_out = 1'b0;
            ID_EX_bubble_out = 1'b1;
            state_d          = RUN;
            flush_cnt_d      = 3'd0;
        end else if (branch_taken_in) begin
            flush_branch_out = 1'b1;
            ID_EX_bubble_out = 1'b1;
            if (MULTI_FLUSH) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == FLUSH) begin
            // Remaining flush cycles discard whatever the front end fetched.
            flush_branch_out = 1'b1;
            ID_EX_bubble_out = 1'b1;
            if (flush_cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
        end else if (jump_in) begin
            flush_jump_out = 1'b1;
            state_d        = RUN;
        end else if (load_use && (state_q != LOAD_STALL)) begin
            PC_write_out     = 1'b0;
            IF_ID_enable_out = 1'b0;
            ID_EX_bubble_out = 1'b1;
            state_d          = LOAD_STALL;
        end else if (!imem_ready_in) begin
            PC_write_out     = 1'b0;
            IF_ID_enable_out = 1'b0;
            ID_EX_bubble_out = 1'b1;
            state_d          = IMEM_WAIT;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_en, flush_en;

    assign stall_en = !reset_in && !PC_write_out;
    assign flush_en = !reset_in && (flush_jump_out || flush_branch_out);

    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk       (clk),
        .reset_in  (reset_in),
        .en_in     (stall_en),
        .count_out (stall_cycles_out)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk       (clk),
        .reset_in  (reset_in),
        .en_in     (flush_en),
        .count_out (flush_cycles_out)
    );
`else
    assign stall_cycles_out = '0;
    assign flush_cycles_out = '0;
`endif

endmodule
